// File: rtl/toaplan2_pkg.sv
// Shared constants and FSM state type for the Toaplan 2 graphics ROM arbiter.
// Slot indices follow the packing order of the requester buses.
package toaplan2_pkg;

    localparam int NSLOT  = 4;
    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] SLOT_GFX  = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_SCR0 = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_SCR1 = 2'd2;
    localparam logic [SLOT_W-1:0] SLOT_SCR2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        FILL
    } arb_state_t;

endpackage

// File: rtl/toaplan2_rr_pick.sv
// Round-robin picker: first requesting slot at or after the rr pointer.
// Purely combinational.
module toaplan2_rr_pick
    import toaplan2_pkg::*;
(
    input  logic [NSLOT-1:0]  req,
    input  logic [SLOT_W-1:0] rr,
    output logic [NSLOT-1:0]  gnt,
    output logic [SLOT_W-1:0] idx,
    output logic              any
);

    logic [SLOT_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = rr;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            cand = rr + SLOT_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        gnt[idx] = any;
    end

endmodule

// File: rtl/toaplan2_gfx_arbiter.sv
// Shares one SDRAM bank read port among the GFX and three scroll-layer requesters,
// with a one-entry 32-bit cache per requester and round-robin scheduling.
module toaplan2_gfx_arbiter
    import toaplan2_pkg::*;
#(
    parameter int          AW      = 22,
    parameter logic [21:0] OFFSET0 = 22'h000000,
    parameter logic [21:0] OFFSET1 = 22'h000000,
    parameter logic [21:0] OFFSET2 = 22'h000000,
    parameter logic [21:0] OFFSET3 = 22'h000000
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                DOWNLOADING,
    input  logic [NSLOT-1:0]    SLOT_CS,
    input  logic [NSLOT*AW-1:0] SLOT_ADDR,
    output logic [NSLOT-1:0]    SLOT_OK,
    output logic [NSLOT*32-1:0] SLOT_DOUT,
    output logic [21:0]         BA_ADDR,
    output logic                BA_RD,
    input  logic                BA_ACK,
    input  logic                BA_DOK,
    input  logic                BA_RDY,
    input  logic [15:0]         DATA_READ
);

    arb_state_t state, state_nx;

    logic [AW-1:0]     tag   [NSLOT];
    logic [31:0]       cdata [NSLOT];
    logic [NSLOT-1:0]  valid;
    logic [AW-1:0]     slot_addr [NSLOT];
    logic [NSLOT-1:0]  hit;
    logic [NSLOT-1:0]  pending;
    logic [NSLOT-1:0]  inflight;

    logic [SLOT_W-1:0] rr;
    logic [SLOT_W-1:0] gnt;
    logic [NSLOT-1:0]  gnt_oh;
    logic [AW-1:0]     gaddr;
    logic [31:0]       asm_word;
    logic              wcnt;

    logic [NSLOT-1:0]  pick_gnt;
    logic [SLOT_W-1:0] pick_idx;
    logic              pick_any;
    logic [AW-1:0]     pick_addr;
    logic [21:0]       offset_sel;
    logic [21:0]       ba_next;
    logic              grant_en;

    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        assign slot_addr[i]         = SLOT_ADDR[i*AW +: AW];
        assign hit[i]               = SLOT_CS[i] & valid[i] & (slot_addr[i] == tag[i]);
        assign SLOT_DOUT[i*32 +: 32] = cdata[i];
    end

    assign SLOT_OK  = hit;
    // The slot being fetched must not be re-picked until its fill has landed.
    assign inflight = (state != IDLE) ? gnt_oh : '0;
    assign pending  = SLOT_CS & ~hit & ~inflight;

    toaplan2_rr_pick u_pick (
        .req (pending),
        .rr  (rr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign pick_addr = slot_addr[pick_idx];

    always_comb begin
        offset_sel = OFFSET0;
        case (pick_idx)
            SLOT_GFX:  offset_sel = OFFSET0;
            SLOT_SCR0: offset_sel = OFFSET1;
            SLOT_SCR1: offset_sel = OFFSET2;
            SLOT_SCR2: offset_sel = OFFSET3;
            default:   offset_sel = OFFSET0;
        endcase
    end

    assign ba_next = offset_sel + 22'({pick_addr[AW-2:0], 1'b0});

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_en = 1'b0;
        case (state)
            IDLE: begin
                if (!DOWNLOADING && pick_any) begin
                    grant_en = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ:  if (BA_ACK) state_nx = DATA;
            DATA: if (BA_DOK && (BA_RDY || wcnt)) state_nx = FILL;
            FILL: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BA_RD    <= 1'b0;
            BA_ADDR  <= '0;
            rr       <= '0;
            gnt      <= '0;
            gnt_oh   <= '0;
            gaddr    <= '0;
            asm_word <= '0;
            wcnt     <= 1'b0;
            valid    <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                tag[i]   <= '0;
                cdata[i] <= '0;
            end
        end else begin
            if (grant_en) begin
                gnt     <= pick_idx;
                gnt_oh  <= pick_gnt;
                gaddr   <= pick_addr;
                BA_ADDR <= ba_next;
                BA_RD   <= 1'b1;
            end
            // A DOK coinciding with ACK is dropped because capture only happens in DATA.
            if (state == REQ && BA_ACK) begin
                BA_RD <= 1'b0;
                wcnt  <= 1'b0;
            end
            if (state == DATA && BA_DOK) begin
                if (!wcnt) asm_word[15:0]  <= DATA_READ;
                else       asm_word[31:16] <= DATA_READ;
                wcnt <= 1'b1;
            end
            if (state == FILL) begin
                tag[gnt]   <= gaddr;
                cdata[gnt] <= asm_word;
                valid[gnt] <= 1'b1;
                rr         <= gnt + 2'd1;
            end
            // ROM contents are changing; this must override a concurrent fill.
            if (DOWNLOADING) valid <= '0;
        end
    end

endmodule

// File: tb/tb_toaplan2_gfx_arbiter.sv
// Directed bench for toaplan2_gfx_arbiter: expected fetches are queued as misses
// are created and retired as the SDRAM model serves each request.
module tb_toaplan2_gfx_arbiter;
    import toaplan2_pkg::*;

    localparam int AW = 22;
    localparam logic [21:0] OFF0 = 22'h000000;
    localparam logic [21:0] OFF1 = 22'h100000;
    localparam logic [21:0] OFF2 = 22'h200000;
    localparam logic [21:0] OFF3 = 22'h3FFFF0;

    logic                CLK = 1'b0;
    logic                RESET_N = 1'b0;
    logic                DOWNLOADING = 1'b0;
    logic [NSLOT-1:0]    SLOT_CS = '0;
    logic [NSLOT*AW-1:0] SLOT_ADDR = '0;
    logic [NSLOT-1:0]    SLOT_OK;
    logic [NSLOT*32-1:0] SLOT_DOUT;
    logic [21:0]         BA_ADDR;
    logic                BA_RD;
    logic                BA_ACK = 1'b0;
    logic                BA_DOK = 1'b0;
    logic                BA_RDY = 1'b0;
    logic [15:0]         DATA_READ = '0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          slot;
        logic [21:0] ba_addr;
        logic [31:0] word;
        logic        ok;
    } sb_entry_t;

    sb_entry_t sb[$];

    toaplan2_gfx_arbiter #(
        .AW      (AW),
        .OFFSET0 (OFF0),
        .OFFSET1 (OFF1),
        .OFFSET2 (OFF2),
        .OFFSET3 (OFF3)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .DOWNLOADING (DOWNLOADING),
        .SLOT_CS     (SLOT_CS),
        .SLOT_ADDR   (SLOT_ADDR),
        .SLOT_OK     (SLOT_OK),
        .SLOT_DOUT   (SLOT_DOUT),
        .BA_ADDR     (BA_ADDR),
        .BA_RD       (BA_RD),
        .BA_ACK      (BA_ACK),
        .BA_DOK      (BA_DOK),
        .BA_RDY      (BA_RDY),
        .DATA_READ   (DATA_READ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] exp_ba(input int s, input logic [21:0] a);
        logic [21:0] off;
        case (s)
            0: off = OFF0;
            1: off = OFF1;
            2: off = OFF2;
            default: off = OFF3;
        endcase
        return off + {a[20:0], 1'b0};
    endfunction

    function automatic logic [31:0] word_for(input int s, input logic [21:0] a);
        return {4'(s), 6'h2A, a};
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_addr(input int s, input logic [21:0] a);
        SLOT_ADDR[s*AW +: AW] = a;
    endtask

    task automatic push_miss(input int s, input logic [21:0] a, input logic ok);
        sb_entry_t e;
        e.slot = s; e.ba_addr = exp_ba(s, a); e.word = word_for(s, a); e.ok = ok;
        sb.push_back(e);
    endtask

    // SDRAM model: waits for a request, checks it against the oldest expected fetch,
    // acks after ack_delay cycles and returns two words; ends once the fill is visible.
    task automatic serve(input int ack_delay, input bit dl_in_req,
                         input bit chg_in_data, input logic [21:0] chg_addr);
        sb_entry_t e;
        int n;
        n = 0;
        while (BA_RD !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("rd_seen", 64'(BA_RD), 64'd1);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk($sformatf("ba_addr_s%0d", e.slot), 64'(BA_ADDR), 64'(e.ba_addr));
        if (dl_in_req) DOWNLOADING = 1'b1;
        repeat (ack_delay) begin
            tick();
            chk("rd_held", 64'(BA_RD), 64'd1);
            chk("addr_held", 64'(BA_ADDR), 64'(e.ba_addr));
        end
        BA_ACK = 1'b1;
        tick();
        BA_ACK = 1'b0;
        chk("rd_drop", 64'(BA_RD), 64'd0);
        BA_DOK = 1'b1;
        DATA_READ = e.word[15:0];
        if (chg_in_data) set_addr(2, chg_addr);
        tick();
        DATA_READ = e.word[31:16];
        BA_RDY = 1'b1;
        tick();
        BA_DOK = 1'b0;
        BA_RDY = 1'b0;
        DATA_READ = '0;
        tick();
        #1;
        chk($sformatf("ok_s%0d", e.slot), 64'(SLOT_OK[e.slot]), 64'(e.ok));
        chk($sformatf("dout_s%0d", e.slot), 64'(SLOT_DOUT[e.slot*32 +: 32]), 64'(e.word));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        sb_entry_t e;

        // Reset state
        #12;
        chk("rst_ok", 64'(SLOT_OK), 64'd0);
        chk("rst_dout", 64'(SLOT_DOUT[63:0]), 64'd0);
        chk("rst_rd", 64'(BA_RD), 64'd0);
        chk("rst_addr", 64'(BA_ADDR), 64'd0);
        tick();
        RESET_N = 1'b1;
        tick();

        // Single miss on slot 0 with fixed burst words
        SLOT_CS = 4'b0001;
        set_addr(0, 22'h000010);
        #1;
        chk("miss_ok0", 64'(SLOT_OK[0]), 64'd0);
        e.slot = 0; e.ba_addr = 22'h000020; e.word = 32'hABCD1234; e.ok = 1'b1;
        sb.push_back(e);
        serve(2, 1'b0, 1'b0, '0);

        // Hit after CS drop
        SLOT_CS = 4'b0000;
        #1;
        chk("cs_low_ok0", 64'(SLOT_OK[0]), 64'd0);
        repeat (5) tick();
        SLOT_CS = 4'b0001;
        #1;
        chk("hit_ok0", 64'(SLOT_OK[0]), 64'd1);
        chk("hit_dout0", 64'(SLOT_DOUT[31:0]), 64'h00000000ABCD1234);
        repeat (3) begin
            tick();
            chk("hit_no_rd", 64'(BA_RD), 64'd0);
        end

        // Round-robin from a clean rr=0: four simultaneous misses
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        for (int s = 0; s < 4; s++) begin
            set_addr(s, 22'h000020 + 22'(s));
            push_miss(s, 22'h000020 + 22'(s), 1'b1);
        end
        SLOT_CS = 4'b1111;
        for (int k = 0; k < 4; k++) serve(k % 3, 1'b0, 1'b0, '0);
        chk("rr_all_ok", 64'(SLOT_OK), 64'hF);

        // Slots 1 and 3 miss again with rr back at 0
        set_addr(1, 22'h000031);
        set_addr(3, 22'h000033);
        push_miss(1, 22'h000031, 1'b1);
        push_miss(3, 22'h000033, 1'b1);
        serve(1, 1'b0, 1'b0, '0);
        serve(0, 1'b0, 1'b0, '0);

        // Address change during DATA: fill lands under the old tag, refetch follows
        set_addr(2, 22'h000100);
        push_miss(2, 22'h000100, 1'b0);
        serve(1, 1'b0, 1'b1, 22'h000104);
        push_miss(2, 22'h000104, 1'b1);
        serve(1, 1'b0, 1'b0, '0);
        chk("chg_all_ok", 64'(SLOT_OK), 64'hF);

        // DOWNLOADING raised during REQ
        set_addr(0, 22'h000040);
        push_miss(0, 22'h000040, 1'b0);
        serve(2, 1'b1, 1'b0, '0);
        chk("dl_ok_clear", 64'(SLOT_OK), 64'h0);
        repeat (4) begin
            tick();
            chk("dl_no_rd", 64'(BA_RD), 64'd0);
        end
        DOWNLOADING = 1'b0;
        push_miss(1, 22'h000031, 1'b1);
        push_miss(2, 22'h000104, 1'b1);
        push_miss(3, 22'h000033, 1'b1);
        push_miss(0, 22'h000040, 1'b1);
        for (int k = 0; k < 4; k++) serve(1, 1'b0, 1'b0, '0);
        chk("dl_refetch_ok", 64'(SLOT_OK), 64'hF);

        // Async reset pulse during DATA
        SLOT_CS = 4'b0001;
        set_addr(0, 22'h000050);
        n = 0;
        while (BA_RD !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("rst_rd_seen", 64'(BA_RD), 64'd1);
        BA_ACK = 1'b1;
        tick();
        BA_ACK = 1'b0;
        BA_DOK = 1'b1;
        DATA_READ = 16'h5555;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_rd", 64'(BA_RD), 64'd0);
        chk("arst_ok", 64'(SLOT_OK), 64'd0);
        chk("arst_state", 64'(dut.state), 64'(IDLE));
        chk("arst_dout", 64'(SLOT_DOUT[63:0]), 64'd0);
        tick();
        BA_DOK = 1'b0;
        DATA_READ = '0;
        set_addr(0, 22'h000010);
        RESET_N = 1'b1;
        e.slot = 0; e.ba_addr = 22'h000020; e.word = 32'hABCD1234; e.ok = 1'b1;
        sb.push_back(e);
        serve(2, 1'b0, 1'b0, '0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
